hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard and multiply/divide sequencing controller for the 5-stage MIPS core. Sits in ID, directly upstream of the ID/EX pipeline register. Generates its `clr` input (`id_ex_clr`) plus PC / IF/ID hold and flush controls. Detects load-use and HI/LO hazards, squashes wrong-path instructions when MEM resolves a taken branch or jump, and owns the multi-cycle busy counter for the HI/LO multiply/divide unit.

## Interface
- `MULT_CYCLES`, default 4: multiply latency in cycles; legal range 1..63.
- `DIV_CYCLES`, default 32: divide latency in cycles; legal range 1..63.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `id_rs`, `id_rt`  input  5 each  source register addresses of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`  input  1 each  the ID instruction actually reads that operand.
- `id_hilo_use`  input  1  the ID instruction reads or writes HI/LO, or starts a mult/div.
- `ex_mem_read`  input  1  the EX-stage instruction is a load.
- `ex_rf_wen`  input  1  the EX-stage instruction writes the register file.
- `ex_rf_waddr`  input  5  destination register of the EX-stage instruction.
- `ex_md_start`  input  1  the EX-stage instruction is mult/multu/div/divu.
- `ex_md_is_mult`  input  1  qualifies `ex_md_start`: 1 selects the multiply latency, 0 the divide latency.
- `mem_redirect`  input  1  MEM resolved a taken branch, jump or jump-register.
- `pc_stall`, `if_id_stall`  output  1 each  hold PC and IF/ID.
- `if_id_flush`  output  1  load a bubble into IF/ID.
- `id_ex_clr`  output  1  drives the ID/EX register's `clr`.
- `ex_mem_clr`  output  1  bubble into EX/MEM.
- `md_busy`  output  1  mult/div unit in progress (registered).
- `md_done`  output  1  one-cycle completion pulse (registered).
- `md_err`  output  1  sticky: start was issued while busy.
- `stall_cnt`, `flush_cnt`  output  16 each  saturating performance counters.

## Operation
Combinational hazard terms:
- **load_use** = `ex_mem_read` & `ex_rf_wen` & (`ex_rf_waddr` ≠ 0) & ((`id_uses_rs` & `id_rs` = `ex_rf_waddr`) | (`id_uses_rt` & `id_rt` = `ex_rf_waddr`)).
- **hilo_haz** = `id_hilo_use` & (`md_busy` | `ex_md_start`).
- **stall** = (load_use | hilo_haz) & !`mem_redirect`.

Output equations:
- `pc_stall` = `if_id_stall` = stall.
- `if_id_flush` = `ex_mem_clr` = `mem_redirect`.
- `id_ex_clr` = stall | `mem_redirect`.
- Redirect has priority over stall. The stalled instruction is on the wrong path and is squashed.

Mult/div FSM:
- States: IDLE, BUSY. The down-counter `cnt` is 6 bits wide.
- **IDLE**: when `ex_md_start` & !`mem_redirect` → BUSY. `cnt` loads `MULT_CYCLES`-1 if `ex_md_is_mult`, else `DIV_CYCLES`-1. A start qualified by `mem_redirect` is discarded.
- **BUSY**: if `cnt` = 0 → IDLE and `md_done` is set for one cycle; otherwise `cnt` decrements.
- **Start while BUSY**: `ex_md_start` in BUSY (illegal, because hilo_haz should prevent it) is ignored. The counter is not reloaded and `md_err` sets until reset.
- `md_busy` = (state = BUSY).

Performance counters:
- `stall_cnt` increments on every cycle with stall = 1.
- `flush_cnt` increments on every cycle with `mem_redirect` = 1.
- Both saturate at 16'hFFFF and do not wrap.

## Timing
- All outputs are 0 after reset: state IDLE, `cnt` = 0, both counters 0, `md_err` 0.
- `rst` low clears all state immediately, mid-operation included. An in-progress mult/div is abandoned, with no `md_done`.
- Stall and flush outputs are combinational, valid in the same cycle as their inputs, with no registered latency.
- Start accepted at edge T:
  - `md_busy` is high for exactly N cycles, T+1 .. T+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - `md_done` is high in cycle T+N+1 only, with `md_busy` low.
  - A new start may be accepted at the edge ending cycle T+N+1.
- hilo_haz covers the start cycle itself via `ex_md_start`. An HI/LO reader directly behind a mult stalls N+1 cycles and issues in the cycle `md_done` is high.
- A load-use stall lasts exactly 1 cycle: next cycle the load is in MEM and forwarding covers it.

## Test plan
- **Load-use**: EX `lw $5`, ID `add` with rs = 5 and `id_uses_rs` = 1 → `pc_stall` = `if_id_stall` = `id_ex_clr` = 1 for one cycle. With `ex_rf_waddr` = 0 → no stall. With `id_uses_rs` = 0 → no stall.
- **Multiply**: `ex_md_start` = 1, `ex_md_is_mult` = 1, `MULT_CYCLES` = 4, followed by `mfhi` in ID → `md_busy` high 4 cycles, stall for 5 cycles, `md_done` pulses in cycle 6, `stall_cnt` = 5.
- **Divide**: `DIV_CYCLES` = 32 → `md_busy` high exactly 32 cycles, one `md_done` pulse.
- **Redirect priority**: `mem_redirect` = 1 coincident with load_use and `ex_md_start` → `if_id_flush` = `ex_mem_clr` = `id_ex_clr` = 1, `pc_stall` = 0, FSM stays IDLE, `flush_cnt` +1.
- **Mid-operation reset**: `rst` low at cycle 2 of a divide → `md_busy` = 0 immediately. `md_done` never pulses and all counters read 0 after reset release.
- **Illegal start**: `ex_md_start` while BUSY → `md_err` = 1 sticky and the original busy window is unchanged. Also force 70000 stall cycles → `stall_cnt` = 16'hFFFF.

Source files
------------

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use / HI-LO hazard detection, redirect squash and mult/div sequencer
// Stall/flush outputs are combinational; mult/div status and perf counters are registered.
module hazard_unit #(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        id_hilo_use,
   input  logic        ex_mem_read,
   input  logic        ex_rf_wen,
   input  logic [4:0]  ex_rf_waddr,
   input  logic        ex_md_start,
   input  logic        ex_md_is_mult,
   input  logic        mem_redirect,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        if_id_flush,
   output logic        id_ex_clr,
   output logic        ex_mem_clr,
   output logic        md_busy,
   output logic        md_done,
   output logic        md_err,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
   localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

   typedef enum logic {IDLE, BUSY} md_state_t;

   md_state_t  state;
   logic [5:0] cnt;
   logic       load_use;
   logic       hilo_haz;
   logic       stall;

   always_comb begin
      load_use = ex_mem_read && ex_rf_wen && (ex_rf_waddr != 5'd0) &&
                 ((id_uses_rs && (id_rs == ex_rf_waddr)) ||
                  (id_uses_rt && (id_rt == ex_rf_waddr)));
      // The start cycle itself is covered by ex_md_start, before md_busy rises.
      hilo_haz = id_hilo_use && (md_busy || ex_md_start);
      // A redirect squashes the stalled instruction, so it wins over stall.
      stall    = (load_use || hilo_haz) && !mem_redirect;
   end

   assign pc_stall    = stall;
   assign if_id_stall = stall;
   assign if_id_flush = mem_redirect;
   assign ex_mem_clr  = mem_redirect;
   assign id_ex_clr   = stall || mem_redirect;
   assign md_busy     = (state == BUSY);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= 6'd0;
         md_done <= 1'b0;
         md_err  <= 1'b0;
      end else begin
         md_done <= 1'b0;
         case (state)
            IDLE: begin
               if (ex_md_start && !mem_redirect) begin
                  state <= BUSY;
                  cnt   <= ex_md_is_mult ? MULT_LOAD : DIV_LOAD;
               end
            end
            BUSY: begin
               // A start here means the hazard logic was bypassed: flag it, keep the window.
               if (ex_md_start)
                  md_err <= 1'b1;
               if (cnt == 6'd0) begin
                  state   <= IDLE;
                  md_done <= 1'b1;
               end else begin
                  cnt <= cnt - 6'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else begin
         if (stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
         if (mem_redirect && (flush_cnt != 16'hFFFF))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_hazard_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs, id_rt, ex_rf_waddr;
   logic        id_uses_rs, id_uses_rt, id_hilo_use;
   logic        ex_mem_read, ex_rf_wen, ex_md_start, ex_md_is_mult, mem_redirect;
   logic        pc_stall, if_id_stall, if_id_flush, id_ex_clr, ex_mem_clr;
   logic        md_busy, md_done, md_err;
   logic [15:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;
   int busy_n, stall_n, done_n, done_at;

   always #5 clk = ~clk;

   hazard_unit #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_hilo_use(id_hilo_use),
      .ex_mem_read(ex_mem_read), .ex_rf_wen(ex_rf_wen), .ex_rf_waddr(ex_rf_waddr),
      .ex_md_start(ex_md_start), .ex_md_is_mult(ex_md_is_mult),
      .mem_redirect(mem_redirect),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_clr(id_ex_clr), .ex_mem_clr(ex_mem_clr),
      .md_busy(md_busy), .md_done(md_done), .md_err(md_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      id_rs = 5'd0; id_rt = 5'd0; ex_rf_waddr = 5'd0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_hilo_use = 1'b0;
      ex_mem_read = 1'b0; ex_rf_wen = 1'b0;
      ex_md_start = 1'b0; ex_md_is_mult = 1'b0; mem_redirect = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic set_load_use();
      ex_mem_read = 1'b1; ex_rf_wen = 1'b1; ex_rf_waddr = 5'd5;
      id_rs = 5'd5; id_uses_rs = 1'b1;
   endtask

   initial begin
      do_reset();
      #1;
      check("rst_pc_stall", pc_stall, 0);
      check("rst_id_ex_clr", id_ex_clr, 0);
      check("rst_flush", if_id_flush, 0);
      check("rst_busy", md_busy, 0);
      check("rst_done", md_done, 0);
      check("rst_err", md_err, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_flush_cnt", flush_cnt, 0);

      // load-use
      tick();
      set_load_use();
      #1;
      check("lu_pc_stall", pc_stall, 1);
      check("lu_if_id_stall", if_id_stall, 1);
      check("lu_id_ex_clr", id_ex_clr, 1);
      check("lu_flush", if_id_flush, 0);
      tick();
      clear_inputs();
      #1;
      check("lu_one_cycle", pc_stall, 0);
      check("lu_stall_cnt", stall_cnt, 1);
      set_load_use();
      ex_rf_waddr = 5'd0; id_rs = 5'd0;
      #1;
      check("lu_r0_no_stall", pc_stall, 0);
      set_load_use();
      id_uses_rs = 1'b0;
      #1;
      check("lu_unused_rs", pc_stall, 0);
      id_rt = 5'd5; id_uses_rt = 1'b1;
      #1;
      check("lu_rt_stall", id_ex_clr, 1);
      clear_inputs();

      // multiply followed by mfhi
      do_reset();
      busy_n = 0; stall_n = 0; done_n = 0; done_at = 0;
      for (int c = 1; c <= 10; c++) begin
         if (c == 1) begin ex_md_start = 1'b1; ex_md_is_mult = 1'b1; id_hilo_use = 1'b1; end
         if (c == 2) ex_md_start = 1'b0;
         if (c == 7) id_hilo_use = 1'b0;
         #1;
         if (md_busy) busy_n++;
         if (pc_stall) stall_n++;
         if (md_done) begin done_n++; done_at = c; end
         if (c == 6) check("mul_issue_on_done", pc_stall, 0);
         tick();
      end
      check("mul_busy_cycles", busy_n, 4);
      check("mul_stall_cycles", stall_n, 5);
      check("mul_done_pulses", done_n, 1);
      check("mul_done_cycle", done_at, 6);
      check("mul_stall_cnt", stall_cnt, 5);

      // divide
      do_reset();
      busy_n = 0; done_n = 0; done_at = 0;
      for (int c = 1; c <= 40; c++) begin
         ex_md_start = (c == 1);
         #1;
         if (md_busy) busy_n++;
         if (md_done) begin done_n++; done_at = c; end
         tick();
      end
      check("div_busy_cycles", busy_n, 32);
      check("div_done_pulses", done_n, 1);
      check("div_done_cycle", done_at, 34);

      // redirect priority
      do_reset();
      set_load_use();
      ex_md_start = 1'b1; ex_md_is_mult = 1'b1; id_hilo_use = 1'b1; mem_redirect = 1'b1;
      #1;
      check("rd_if_id_flush", if_id_flush, 1);
      check("rd_ex_mem_clr", ex_mem_clr, 1);
      check("rd_id_ex_clr", id_ex_clr, 1);
      check("rd_pc_stall", pc_stall, 0);
      check("rd_if_id_stall", if_id_stall, 0);
      tick();
      clear_inputs();
      #1;
      check("rd_fsm_idle", md_busy, 0);
      check("rd_flush_cnt", flush_cnt, 1);
      check("rd_stall_cnt", stall_cnt, 0);

      // mid-operation reset
      do_reset();
      mem_redirect = 1'b1;
      tick();
      clear_inputs();
      set_load_use();
      tick();
      clear_inputs();
      ex_md_start = 1'b1;
      tick();
      ex_md_start = 1'b0;
      #1;
      check("mr_busy_before", md_busy, 1);
      check("mr_stall_cnt_before", stall_cnt, 1);
      check("mr_flush_cnt_before", flush_cnt, 1);
      rst = 1'b0;
      #1;
      check("mr_busy_async", md_busy, 0);
      check("mr_stall_cnt_async", stall_cnt, 0);
      tick();
      tick();
      rst = 1'b1;
      done_n = 0;
      for (int c = 1; c <= 40; c++) begin
         #1;
         if (md_done) done_n++;
         tick();
      end
      check("mr_no_done", done_n, 0);
      check("mr_busy_after", md_busy, 0);
      check("mr_stall_cnt_after", stall_cnt, 0);
      check("mr_flush_cnt_after", flush_cnt, 0);

      // illegal start while busy
      do_reset();
      busy_n = 0; done_n = 0; done_at = 0;
      for (int c = 1; c <= 10; c++) begin
         ex_md_start = (c == 1) || (c == 3);
         ex_md_is_mult = (c == 1);
         #1;
         if (c == 2) check("il_err_before", md_err, 0);
         if (md_busy) busy_n++;
         if (md_done) begin done_n++; done_at = c; end
         tick();
      end
      check("il_err_sticky", md_err, 1);
      check("il_busy_cycles", busy_n, 4);
      check("il_done_cycle", done_at, 6);
      check("il_done_pulses", done_n, 1);

      // stall counter saturation
      do_reset();
      set_load_use();
      repeat (65534) tick();
      check("sat_fffe", stall_cnt, 16'hFFFE);
      tick();
      check("sat_ffff", stall_cnt, 16'hFFFF);
      repeat (70000 - 65535) tick();
      check("sat_hold", stall_cnt, 16'hFFFF);
      check("sat_flush_cnt", flush_cnt, 0);
      clear_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
